// File: rtl/pow2_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : pow2_share_arbiter_if
// Purpose : Request/response bundle for the shared pow2 unit arbiter.
// Rev     : 1.0  initial release
// ============================================================================
interface pow2_share_arbiter_if #(
  parameter int W     = 16,
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*W-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic               rsp_valid;
  logic [W-1:0]       rsp_data;
  logic [ID_W-1:0]    rsp_id;
  logic               rsp_ready;
  logic [1:0]         inflight;
  logic               idle;

  // Requesters and response consumer side.
  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, inflight, idle
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, inflight, idle
  );
endinterface
`default_nettype wire

// File: rtl/pow2_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : pow2_share_arbiter
// Purpose : Round-robin sharing of one pow2 approximation unit, 2-stage pipe.
// Rev     : 1.0  initial release
// ============================================================================
module pow2_share_arbiter #(
  parameter int W         = 16,
  parameter int INT_WIDTH = 3,
  parameter int FRC_WIDTH = 12,
  parameter int N_REQ     = 4,
  parameter int ID_W      = 2
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  pow2_share_arbiter_if.slave  bus
);

  localparam logic [ID_W-1:0] c_last_idx = ID_W'(N_REQ - 1);

  // Approximates 2^x as {1,f} scaled by the sign and a one-step exponent.
  function automatic logic [W-1:0] f_pow2(input logic [W-1:0] x);
    logic                 s;
    logic [INT_WIDTH-1:0] n;
    logic [FRC_WIDTH-1:0] f;
    logic [W-1:0]         base;
    logic [W-1:0]         y1;
    logic                 shift;
    s     = x[W-1];
    n     = x[W-2:FRC_WIDTH];
    f     = x[FRC_WIDTH-1:0];
    base  = {{(W-FRC_WIDTH-1){1'b0}}, 1'b1, f};
    y1    = s ? (base >> 1) : base;
    shift = (n != '0) && (n != '1);
    return shift ? (s ? (y1 >> 1) : (y1 << 1)) : y1;
  endfunction

  logic              r_s1_v;
  logic [W-1:0]      r_s1_data;
  logic [ID_W-1:0]   r_s1_id;
  logic              r_s2_v;
  logic [W-1:0]      r_s2_data;
  logic [ID_W-1:0]   r_s2_id;
  logic [ID_W-1:0]   r_ptr;

  logic              w_s1_adv;
  logic              w_s2_adv;
  logic              w_any;
  logic [ID_W-1:0]   w_grant_idx;
  logic [ID_W-1:0]   w_ptr_nxt;
  logic [W-1:0]      w_sel_data;
  logic [N_REQ-1:0]  w_req_ready;
  logic [1:0]        w_inflight;

  assign w_s2_adv = !r_s2_v || bus.rsp_ready;
  assign w_s1_adv = !r_s1_v || w_s2_adv;
  assign w_any    = |bus.req_valid;

  // Rotating-priority search starting at r_ptr.
  always_comb begin : p_arb
    int              v_idx;
    logic            v_found;
    logic [ID_W-1:0] v_sel;
    w_grant_idx = '0;
    v_found     = 1'b0;
    v_idx       = 0;
    v_sel       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      v_idx = int'(r_ptr) + k;
      if (v_idx >= N_REQ) begin
        v_idx = v_idx - N_REQ;
      end
      v_sel = ID_W'(v_idx);
      if (!v_found && bus.req_valid[v_sel]) begin
        v_found     = 1'b1;
        w_grant_idx = v_sel;
      end
    end
  end

  always_comb begin
    w_sel_data = bus.req_data[int'(w_grant_idx)*W +: W];
    w_ptr_nxt  = (w_grant_idx == c_last_idx) ? '0 : (w_grant_idx + 1'b1);
  end

  // Ready is forced low while reset is held so nothing looks accepted.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
    assign w_req_ready[gi] = rst_n && w_s1_adv && w_any && (w_grant_idx == ID_W'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr     <= '0;
      r_s1_v    <= 1'b0;
      r_s1_data <= '0;
      r_s1_id   <= '0;
    end else if (w_s1_adv) begin
      r_s1_v <= w_any;
      if (w_any) begin
        r_s1_data <= w_sel_data;
        r_s1_id   <= w_grant_idx;
        r_ptr     <= w_ptr_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_v    <= 1'b0;
      r_s2_data <= '0;
      r_s2_id   <= '0;
    end else if (w_s2_adv) begin
      r_s2_v    <= r_s1_v;
      r_s2_data <= f_pow2(r_s1_data);
      r_s2_id   <= r_s1_id;
    end
  end

  assign w_inflight    = {1'b0, r_s1_v} + {1'b0, r_s2_v};
  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_s2_v;
  assign bus.rsp_data  = r_s2_data;
  assign bus.rsp_id    = r_s2_id;
  assign bus.inflight  = w_inflight;
  assign bus.idle      = (w_inflight == 2'd0) && !w_any;

endmodule
`default_nettype wire

// File: tb/tb_pow2_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_pow2_share_arbiter
// Purpose : Directed vectors with a queue-based model checked every cycle.
// Rev     : 1.0  initial release
// ============================================================================
module tb_pow2_share_arbiter;
  localparam int W         = 16;
  localparam int INT_WIDTH = 3;
  localparam int FRC_WIDTH = 12;
  localparam int N_REQ     = 4;
  localparam int ID_W      = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pow2_share_arbiter_if #(.W(W), .N_REQ(N_REQ), .ID_W(ID_W)) bus ();

  pow2_share_arbiter #(
    .W(W), .INT_WIDTH(INT_WIDTH), .FRC_WIDTH(FRC_WIDTH), .N_REQ(N_REQ), .ID_W(ID_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [W-1:0]     src [N_REQ][$];
  logic [N_REQ-1:0] acc = '0;

  // Model: accepted-but-not-yet-consumed operations, oldest first.
  int m_ptr = 0;
  int q_d[$];
  int q_id[$];
  int q_t[$];

  int log_d[$];
  int log_id[$];
  int log_t[$];
  int acc_id[$];
  int acc_t[$];

  function automatic void chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void chk_log(input string name, input int k, input int d, input int id);
    if (k >= log_d.size()) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: response %0d missing, only %0d seen", name, k, log_d.size());
    end else begin
      chk({name, "_data"}, log_d[k], d);
      chk({name, "_id"}, log_id[k], id);
    end
  endfunction

  function automatic void chk_acc(input string name, input int k, input int id);
    if (k >= acc_id.size()) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: accept %0d missing, only %0d seen", name, k, acc_id.size());
    end else begin
      chk(name, acc_id[k], id);
    end
  endfunction

  // 2^x as mantissa (1+f) times 2^e, with e built from sign and exponent range.
  function automatic int model_pow2(input int x);
    int s, n, f, m, e, r;
    s = (x >> (W - 1)) & 1;
    n = (x >> FRC_WIDTH) & ((1 << INT_WIDTH) - 1);
    f = x & ((1 << FRC_WIDTH) - 1);
    m = (1 << FRC_WIDTH) + f;
    e = -s;
    if (n != 0 && n != (1 << INT_WIDTH) - 1) e = (s != 0) ? e - 1 : e + 1;
    r = (e >= 0) ? (m << e) : (m >> (-e));
    return r & ((1 << W) - 1);
  endfunction

  // Per-cycle compare against the model, then advance the model across the next edge.
  initial begin : p_compare
    int   g;
    int   ix;
    logic any;
    logic exp_v;
    logic [N_REQ-1:0] exp_rdy;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        q_d.delete(); q_id.delete(); q_t.delete();
        m_ptr = 0;
        acc   = '0;
        chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
        chk("rst_rsp_data", int'(bus.rsp_data), 0);
        chk("rst_rsp_id", int'(bus.rsp_id), 0);
        chk("rst_req_ready", int'(bus.req_ready), 0);
        chk("rst_inflight", int'(bus.inflight), 0);
      end else begin
        any = 1'b0;
        g   = 0;
        for (int k = 0; k < N_REQ; k++) begin
          ix = (m_ptr + k) % N_REQ;
          if (!any && bus.req_valid[ix]) begin
            any = 1'b1;
            g   = ix;
          end
        end
        exp_v   = (q_d.size() > 0) && (q_t[0] <= cyc - 1);
        exp_rdy = (any && (q_d.size() < 2 || bus.rsp_ready)) ? (N_REQ'(1) << g) : '0;

        chk("rsp_valid", int'(bus.rsp_valid), int'(exp_v));
        if (exp_v) begin
          chk("rsp_data", int'(bus.rsp_data), q_d[0]);
          chk("rsp_id", int'(bus.rsp_id), q_id[0]);
        end
        chk("inflight", int'(bus.inflight), q_d.size());
        chk("req_ready", int'(bus.req_ready), int'(exp_rdy));
        chk("idle", int'(bus.idle), int'(q_d.size() == 0 && !any));

        if (exp_v && bus.rsp_ready) begin
          log_d.push_back(int'(bus.rsp_data));
          log_id.push_back(int'(bus.rsp_id));
          log_t.push_back(cyc + 1);
          void'(q_d.pop_front()); void'(q_id.pop_front()); void'(q_t.pop_front());
        end
        if (exp_rdy != '0) begin
          q_d.push_back(model_pow2(int'(bus.req_data[g*W +: W])));
          q_id.push_back(g);
          q_t.push_back(cyc + 1);
          m_ptr = (g + 1) % N_REQ;
        end
        acc = bus.req_ready & bus.req_valid;
        for (int k = 0; k < N_REQ; k++) begin
          if (acc[k]) begin
            acc_id.push_back(k);
            acc_t.push_back(cyc + 1);
          end
        end
      end
    end
  end

  task automatic present();
    for (int i = 0; i < N_REQ; i++) begin
      if (src[i].size() != 0) begin
        bus.req_valid[i]       = 1'b1;
        bus.req_data[i*W +: W] = src[i][0];
      end else begin
        bus.req_valid[i]       = 1'b0;
        bus.req_data[i*W +: W] = '0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N_REQ; i++) begin
      if (acc[i] && src[i].size() != 0) void'(src[i].pop_front());
    end
    present();
  endtask

  function automatic logic all_done();
    logic e;
    e = (q_d.size() == 0);
    for (int i = 0; i < N_REQ; i++) if (src[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (n < budget && !all_done()) begin
      tick();
      n++;
    end
    if (!all_done()) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: pipeline not drained within %0d cycles", name, budget);
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin : p_watchdog
    #500000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : p_main
    int b, ba;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Single requester 0, back to back.
    b = log_d.size(); ba = acc_t.size();
    src[0].push_back(16'h0000);
    src[0].push_back(16'h1000);
    present();
    drain("t1_drain", 50);
    chk_log("t1_r0", b, 16'h1000, 0);
    chk_log("t1_r1", b + 1, 16'h2000, 0);
    if (log_t.size() >= b + 2 && acc_t.size() > ba) begin
      chk("t1_latency", log_t[b] - acc_t[ba], 2);
      chk("t1_spacing", log_t[b+1] - log_t[b], 1);
    end

    // Requester 2, negative and fractional operands.
    b = log_d.size();
    src[2].push_back(16'hF000);
    src[2].push_back(16'h0800);
    src[2].push_back(16'hE000);
    present();
    drain("t2_drain", 50);
    chk_log("t2_r0", b, 16'h0800, 2);
    chk_log("t2_r1", b + 1, 16'h1800, 2);
    chk_log("t2_r2", b + 2, 16'h0400, 2);

    // All four requesters continuously valid from ptr=0.
    pulse_reset();
    b = log_d.size(); ba = acc_t.size();
    for (int i = 0; i < N_REQ; i++)
      for (int k = 0; k < 3; k++) src[i].push_back(W'(16'h1000 * i + 16'h0100 * k + 16'h0010));
    present();
    drain("t3_drain", 100);
    for (int k = 0; k < 12; k++) chk_acc("t3_grant", ba + k, k % 4);
    for (int k = 0; k < 12; k++) if (log_id.size() > b + k) chk("t3_rsp_id", log_id[b+k], k % 4);
    if (acc_t.size() >= ba + 12) chk("t3_rate", acc_t[ba+11] - acc_t[ba], 11);

    // Two in flight, response side stalls five cycles.
    b = log_d.size(); ba = acc_t.size();
    bus.rsp_ready = 1'b0;
    src[0].push_back(16'h0000);
    src[1].push_back(16'h1000);
    src[2].push_back(16'h0800);
    present();
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("t4_req_ready", int'(bus.req_ready), 0);
      chk("t4_inflight", int'(bus.inflight), 2);
      chk("t4_rsp_data", int'(bus.rsp_data), 16'h1000);
      chk("t4_rsp_id", int'(bus.rsp_id), 0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    drain("t4_drain", 50);
    chk_log("t4_r0", b, 16'h1000, 0);
    chk_log("t4_r1", b + 1, 16'h2000, 1);
    chk_log("t4_r2", b + 2, 16'h1800, 2);
    if (log_t.size() >= b + 2 && acc_t.size() >= ba + 3) begin
      chk("t4_accept_on_pop", acc_t[ba+2], log_t[b]);
      chk("t4_drain_order", log_t[b+1] - log_t[b], 1);
    end

    // Bring ptr to 2, then requesters 1 and 3 contend.
    ba = acc_t.size();
    src[1].push_back(16'h2000);
    present();
    drain("t5_prep", 50);
    src[1].push_back(16'h0000);
    src[3].push_back(16'h1000);
    present();
    drain("t5_drain", 50);
    chk_acc("t5_prep_grant", ba, 1);
    chk_acc("t5_first_grant", ba + 1, 3);
    chk_acc("t5_wrap_grant", ba + 2, 1);

    // Reset while stalled with two in flight; ptr=2 on entry.
    ba = acc_t.size();
    bus.rsp_ready = 1'b0;
    src[0].push_back(16'h0400);
    src[1].push_back(16'h0800);
    src[2].push_back(16'h1000);
    present();
    tick();
    tick();
    chk("t6_full", int'(bus.inflight), 2);
    chk_acc("t6_grant0", ba, 2);
    chk_acc("t6_grant1", ba + 1, 0);
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", int'(bus.rsp_valid), 0);
    chk("t6_async_inflight", int'(bus.inflight), 0);
    chk("t6_async_data", int'(bus.rsp_data), 0);
    chk("t6_async_ready", int'(bus.req_ready), 0);
    src[0].push_back(16'h3000);
    present();
    repeat (2) tick();
    b = log_d.size(); ba = acc_t.size();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    drain("t6_drain", 50);
    chk("t6_rsp_count", log_d.size() - b, 2);
    chk_acc("t6_first_grant", ba, 0);
    chk_log("t6_r0", b, 16'h2000, 0);
    chk_log("t6_r1", b + 1, 16'h1800, 1);

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pow2_share_arbiter.md
Name: pow2_share_arbiter

Overview:
- Shares one combinational pow2 approximation unit among N_REQ requesters, e.g. neuron lanes computing exponential decay/growth factors.
- Round-robin arbitration with valid/ready handshakes on every request port and a single tagged response channel.
- Two-stage pipeline: operand register, then result register; full backpressure from the response side.
- Sustains one operation per cycle.

Parameters:
- W, 16, operand/result width (signed fixed point).
- INT_WIDTH, 3, integer field width of the operand, excluding the sign bit.
- FRC_WIDTH, 12, fraction field width (W = 1 + INT_WIDTH + FRC_WIDTH).
- N_REQ, 4, number of requesters (2..16).
- ID_W, 2, tag width; must satisfy 2^ID_W >= N_REQ.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_data  in  N_REQ*W  packed operands; requester i occupies bits [i*W +: W].
- req_ready  out  N_REQ  per-requester accept; one-hot or zero.
- rsp_valid  out  1  result valid.
- rsp_data  out  W  pow2 result.
- rsp_id  out  ID_W  index of the requester that issued the operand.
- rsp_ready  in  1  consumer accepts the result.
- inflight  out  2  number of occupied pipeline stages (0..2).
- idle  out  1  high when inflight==0 and no req_valid bit is asserted.

Behaviour:
- Reset: asynchronous, active-low.
  - Forces s1_v=0, s2_v=0 and priority pointer ptr=0.
  - Clears stored operand, result and ids to 0.
  - Outputs while reset is asserted: rsp_valid=0, rsp_data=0, rsp_id=0, req_ready=0, inflight=0.
  - In-flight operations are discarded; none are replayed after reset releases.
- Handshake rules:
  - A transfer occurs when valid and ready are both high on a rising edge.
  - Requesters hold req_valid and req_data stable until accepted.
  - rsp_valid, rsp_data and rsp_id hold stable while rsp_valid=1 and rsp_ready=0.
- Arbitration:
  - Grant goes to the first i with req_valid[i]=1, searching ptr, ptr+1, ... modulo N_REQ.
  - req_ready[i] = grant[i] & s1_adv.
  - ptr becomes (granted index + 1) mod N_REQ only on an accepted transfer.
  - ptr is unchanged while stalled or when no request is pending.
- Pipeline control:
  - s2_adv = !s2_v | rsp_ready.
  - s1_adv = !s1_v | s2_adv.
- Stage 1:
  - Captures the granted operand and id when s1_adv.
  - s1_v <= any(req_valid) when s1_adv; otherwise s1 holds.
- Stage 2:
  - Captures pow2(s1 operand) and s1 id when s2_adv.
  - s2_v <= s1_v when s2_adv; otherwise s2 holds.
- Outputs: rsp_valid = s2_v, rsp_data = s2 result, rsp_id = s2 id.
- Latency and throughput:
  - An operand accepted at edge T gives rsp_valid=1 after edge T+1, i.e. during the cycle that ends at edge T+2.
  - This holds when no stall is present; back-to-back rate is 1 per cycle.
- Stalls: a full pipeline with rsp_ready=0 drives all req_ready=0. Ordering is strict FIFO; no reordering.
- Same-edge events: a response pop and a new accept on the same edge are both legal.
- inflight = s1_v + s2_v.
- pow2 arithmetic, applied to operand x:
  - Fields: s = x[W-1], n = x[W-2:FRC_WIDTH], f = x[FRC_WIDTH-1:0].
  - base = {1, f}, zero-extended to W bits.
  - y1 = s ? base>>1 : base.
  - shift = (n != 0) && (n != all-ones).
  - y = shift ? (s ? y1>>1 : y1<<1) : y1, truncated to W bits.
- Boundary conditions:
  - Round-robin order wraps modulo N_REQ.
  - A single active requester can issue every cycle.
  - When req_valid drops to 0, s1_v clears on the next s1_adv edge.
  - An out-of-range ptr cannot occur.

Test Plan:
- Single requester 0, x=0x0000 then 0x1000, rsp_ready=1.
  - Expect rsp_data=0x1000 then 0x2000, both with rsp_id=0.
  - Responses appear on consecutive cycles, 2 cycles after each accept.
- Requester 2 sends x=0xF000, then 0x0800.
  - Expect 0x0800 (id 2), then 0x1800.
  - Expect x=0xE000 (s=1, n=6) to return 0x0400.
- All 4 requesters hold valid continuously with rsp_ready=1.
  - Grants in order 0,1,2,3,0,1...; rsp_id follows the same sequence; one accept per cycle.
- Two operands in flight, then rsp_ready=0 for 5 cycles.
  - Expect req_ready=0, inflight=2, and rsp_data/rsp_id frozen.
  - On rsp_ready=1, both results drain in order and one new request is accepted that same cycle.
- Requesters 1 and 3 valid, ptr=2.
  - Expect a grant to 3 first, then 1, with ptr wrapping to 0 after the grant to 3.
- rst_n pulsed low mid-stall with inflight=2.
  - Expect rsp_valid=0, inflight=0 and rsp_data=0 immediately, asynchronously.
  - After release, the first grant goes to the lowest valid index.
